// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM states, port ids and the
// default starvation limit.
package mem_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    typedef enum logic {
        P0 = 1'b0,
        P1 = 1'b1
    } port_id_t;

    localparam int STARVE_LIMIT_DEFAULT = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection for the memory arbiter: p0 has fixed priority unless the
// starvation counter has reached its limit, in which case a waiting p1 wins.
module mem_arb_pick (
    input  logic       p0_valid,
    input  logic       p1_valid,
    input  logic       at_limit,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (p1_valid && (at_limit || !p0_valid)) begin
            grant = 2'b10;
        end else if (p0_valid) begin
            grant = 2'b01;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single memory data port (p0 = MEM stage,
// p1 = loader/debug). Optional per-port grant counters under MEM_ARB_STATS_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             p0_valid,
    output logic             p0_ready,
    input  logic             p0_we,
    input  logic [WIDTH-1:0] p0_addr,
    input  logic [WIDTH-1:0] p0_wdata,
    output logic             p0_rvalid,
    input  logic             p1_valid,
    output logic             p1_ready,
    input  logic             p1_we,
    input  logic [WIDTH-1:0] p1_addr,
    input  logic [WIDTH-1:0] p1_wdata,
    output logic             p1_rvalid,
    output logic [WIDTH-1:0] rdata,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_a,
    output logic [WIDTH-1:0] mem_wd,
    input  logic [WIDTH-1:0] mem_rd
`ifdef MEM_ARB_STATS_EN
    ,output logic [WIDTH-1:0] grant_cnt0
    ,output logic [WIDTH-1:0] grant_cnt1
`endif
);

    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    state_t           state_reg;
    port_id_t         lat_id_reg;
    logic             lat_we_reg;
    logic [WIDTH-1:0] lat_addr_reg;
    logic [WIDTH-1:0] lat_wdata_reg;
    logic [WIDTH-1:0] rdata_reg;
    logic [1:0]       rvalid_reg;
    logic             mem_we_reg;
    logic [CW-1:0]    starve_reg;

    logic       at_limit;
    logic [1:0] grant;
    logic [1:0] accepted;

    assign at_limit = (starve_reg == CW'(STARVE_LIMIT));

    mem_arb_pick u_pick (
        .p0_valid (p0_valid),
        .p1_valid (p1_valid),
        .at_limit (at_limit),
        .grant    (grant)
    );

    // Ready is combinational off the grant; masked during reset so nothing is
    // accepted that the reset edge would then throw away.
    assign accepted = (state_reg == IDLE && !rst) ? grant : 2'b00;
    assign p0_ready = accepted[0];
    assign p1_ready = accepted[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            lat_id_reg    <= P0;
            lat_we_reg    <= 1'b0;
            lat_addr_reg  <= '0;
            lat_wdata_reg <= '0;
            rdata_reg     <= '0;
            rvalid_reg    <= 2'b00;
            mem_we_reg    <= 1'b0;
            starve_reg    <= '0;
        end else begin
            rvalid_reg <= 2'b00;
            mem_we_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (|accepted) begin
                        lat_id_reg    <= accepted[1] ? P1 : P0;
                        lat_we_reg    <= accepted[1] ? p1_we    : p0_we;
                        lat_addr_reg  <= accepted[1] ? p1_addr  : p0_addr;
                        lat_wdata_reg <= accepted[1] ? p1_wdata : p0_wdata;
                        mem_we_reg    <= accepted[1] ? p1_we    : p0_we;
                        state_reg     <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_reg <= IDLE;
                    if (!lat_we_reg) begin
                        rdata_reg  <= mem_rd;
                        rvalid_reg <= {lat_id_reg == P1, lat_id_reg == P0};
                    end
                end
                default: state_reg <= IDLE;
            endcase

            if (!p1_valid || accepted[1]) begin
                starve_reg <= '0;
            end else if (accepted[0]) begin
                starve_reg <= starve_reg + CW'(1);
            end
        end
    end

    assign p0_rvalid = rvalid_reg[0];
    assign p1_rvalid = rvalid_reg[1];
    assign rdata     = rdata_reg;
    assign mem_we    = mem_we_reg;
    assign mem_a     = lat_addr_reg;
    assign mem_wd    = lat_wdata_reg;

`ifdef MEM_ARB_STATS_EN
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        logic [WIDTH-1:0] cnt_reg;
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_reg <= '0;
            end else if (accepted[gi] && cnt_reg != '1) begin
                cnt_reg <= cnt_reg + WIDTH'(1);
            end
        end
    end
    assign grant_cnt0 = g_cnt[0].cnt_reg;
    assign grant_cnt1 = g_cnt[1].cnt_reg;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a transaction-level model.
module tb_mem_arbiter;

    localparam int WIDTH = 16;
    localparam int LIMIT = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             p0_valid, p0_ready, p0_we, p0_rvalid;
    logic [WIDTH-1:0] p0_addr, p0_wdata;
    logic             p1_valid, p1_ready, p1_we, p1_rvalid;
    logic [WIDTH-1:0] p1_addr, p1_wdata;
    logic [WIDTH-1:0] rdata, mem_a, mem_wd, mem_rd;
    logic             mem_we;
`ifdef MEM_ARB_STATS_EN
    logic [WIDTH-1:0] grant_cnt0, grant_cnt1;
`endif

    mem_arbiter #(.WIDTH(WIDTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .p0_valid  (p0_valid),
        .p0_ready  (p0_ready),
        .p0_we     (p0_we),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p0_rvalid (p0_rvalid),
        .p1_valid  (p1_valid),
        .p1_ready  (p1_ready),
        .p1_we     (p1_we),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p1_rvalid (p1_rvalid),
        .rdata     (rdata),
        .mem_we    (mem_we),
        .mem_a     (mem_a),
        .mem_wd    (mem_wd),
        .mem_rd    (mem_rd)
`ifdef MEM_ARB_STATS_EN
        ,.grant_cnt0 (grant_cnt0)
        ,.grant_cnt1 (grant_cnt1)
`endif
    );

    always #5 clk = ~clk;

    // Memory behind the data port: 256 words, aliased on the low address byte.
    logic             mem_init;
    logic [WIDTH-1:0] mem [256];
    assign mem_rd = mem[mem_a[7:0]];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= {8'h5A, 8'(i)};
            mem[5] <= 16'hBEEF;
        end else if (mem_we) begin
            mem[mem_a[7:0]] <= mem_wd;
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        p0_valid = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
        p1_valid = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
    endtask

    task automatic do_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    // Single access on one port; waits a bounded number of cycles for ready.
    task automatic do_access(input logic port, input logic we, input logic [15:0] addr);
        bit got = 0;
        if (port) begin p1_valid = 1; p1_we = we; p1_addr = addr; end
        else      begin p0_valid = 1; p0_we = we; p0_addr = addr; end
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            got = port ? p1_ready : p0_ready;
            @(posedge clk); #1;
        end
        check("access_ready", 32'(got), 32'd1);
        idle_inputs();
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        port;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        exp_mem_we;
        logic [1:0]  exp_rv;
        logic [15:0] exp_rdata;
    } vec_t;

    typedef struct {
        int          acc;
        logic        port;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wd;
        logic [15:0] rd;
    } rec_t;

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  b2b_rdy, b2b_rv;
        logic [15:0] b2b_rd[8];
        logic [9:0]  order;
        int          acc;
        logic [15:0] shadow[256];
        rec_t        q[$];
        logic        pend_v[2], pend_we[2];
        logic [15:0] pend_addr[2], pend_wd[2];
        int          skipped;
        logic [15:0] last_rdata;

        vecs[0] = '{1'b0, 1'b0, 16'h0005, 16'h0000, 1'b0, 2'b01, 16'hBEEF};
        vecs[1] = '{1'b1, 1'b1, 16'h0010, 16'h1234, 1'b1, 2'b00, 16'hBEEF};
        vecs[2] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 2'b10, 16'h1234};
        vecs[3] = '{1'b0, 1'b1, 16'h0020, 16'hCAFE, 1'b1, 2'b00, 16'h1234};
        vecs[4] = '{1'b0, 1'b0, 16'h0020, 16'h0000, 1'b0, 2'b01, 16'hCAFE};
        vecs[5] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 2'b10, 16'h5AFF};
        vecs[6] = '{1'b0, 1'b1, 16'hFFFF, 16'h0001, 1'b1, 2'b00, 16'h5AFF};
        vecs[7] = '{1'b1, 1'b0, 16'h00FF, 16'h0000, 1'b0, 2'b10, 16'h0001};

        idle_inputs();
        mem_init = 1;
        rst = 1;
        @(posedge clk); #1 mem_init = 0;
        @(posedge clk); #1 rst = 0;

        // Reset values
        @(negedge clk);
        check("rst_ready",  32'({p1_ready, p0_ready}), 32'd0);
        check("rst_rvalid", 32'({p1_rvalid, p0_rvalid}), 32'd0);
        check("rst_rdata",  32'(rdata), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_a",  32'(mem_a), 32'd0);
        check("rst_mem_wd", 32'(mem_wd), 32'd0);

        // Directed single-access table
        for (int v = 0; v < 8; v++) begin
            @(posedge clk); #1;
            if (vecs[v].port) begin
                p1_valid = 1; p1_we = vecs[v].we; p1_addr = vecs[v].addr; p1_wdata = vecs[v].wdata;
            end else begin
                p0_valid = 1; p0_we = vecs[v].we; p0_addr = vecs[v].addr; p0_wdata = vecs[v].wdata;
            end
            @(negedge clk);
            check("vec_ready", 32'({p1_ready, p0_ready}), vecs[v].port ? 32'd2 : 32'd1);
            check("vec_rvalid_clear", 32'({p1_rvalid, p0_rvalid}), 32'd0);
            @(posedge clk); #1;
            idle_inputs();
            @(negedge clk);
            check("vec_issue_ready", 32'({p1_ready, p0_ready}), 32'd0);
            check("vec_mem_we", 32'(mem_we), 32'(vecs[v].exp_mem_we));
            check("vec_mem_a",  32'(mem_a), 32'(vecs[v].addr));
            if (vecs[v].exp_mem_we) check("vec_mem_wd", 32'(mem_wd), 32'(vecs[v].wdata));
            @(negedge clk);
            check("vec_rvalid", 32'({p1_rvalid, p0_rvalid}), 32'(vecs[v].exp_rv));
            check("vec_rdata",  32'(rdata), 32'(vecs[v].exp_rdata));
            check("vec_mem_we_off", 32'(mem_we), 32'd0);
            $display("[TB] vec %0d p%0d %s addr=%h wdata=%h rdata=%h", v, vecs[v].port,
                     vecs[v].we ? "WR" : "RD", vecs[v].addr, vecs[v].wdata, rdata);
        end

        // Back-to-back p0 reads: ready every 2 cycles, rvalid 2 cycles after each
        @(posedge clk); #1;
        b2b_rdy = 8'b0001_0101;
        b2b_rv  = 8'b0101_0100;
        b2b_rd[0] = 16'h0001; b2b_rd[1] = 16'h0001;
        b2b_rd[2] = 16'h5A30; b2b_rd[3] = 16'h5A30;
        b2b_rd[4] = 16'h5A31; b2b_rd[5] = 16'h5A31;
        b2b_rd[6] = 16'h5A32; b2b_rd[7] = 16'h5A32;
        acc = 0;
        p0_valid = 1; p0_we = 0; p0_addr = 16'h0030;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("b2b_ready",  32'(p0_ready), 32'(b2b_rdy[k]));
            check("b2b_rvalid", 32'(p0_rvalid), 32'(b2b_rv[k]));
            check("b2b_rdata",  32'(rdata), 32'(b2b_rd[k]));
            if (p0_ready) begin
                acc++;
                $display("[TB] b2b read %0d accepted at cycle %0d", acc, k);
            end
            @(posedge clk); #1;
            if (acc >= 3) p0_valid = 0;
            else p0_addr = 16'h0030 + 16'(acc);
        end

        // Contention with both ports always requesting
        order = 10'b10_0001_0000;
        p0_valid = 1; p0_we = 0; p0_addr = 16'h0050;
        p1_valid = 1; p1_we = 0; p1_addr = 16'h0060;
        for (int g = 0; g < 10; g++) begin
            @(negedge clk);
            check("cont_grant", 32'({p1_ready, p0_ready}), order[g] ? 32'd2 : 32'd1);
            if (g > 0) check("cont_rvalid", 32'({p1_rvalid, p0_rvalid}), order[g-1] ? 32'd2 : 32'd1);
            $display("[TB] contention grant %0d -> ready p0=%0b p1=%0b", g, p0_ready, p1_ready);
            @(posedge clk); #1;
            if (order[g]) p1_addr = p1_addr + 16'd1;
            else          p0_addr = p0_addr + 16'd1;
            @(negedge clk);
            check("cont_issue_ready", 32'({p1_ready, p0_ready}), 32'd0);
            @(posedge clk); #1;
        end
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;

        // Reset during the ISSUE cycle of a write
        p1_valid = 1; p1_we = 1; p1_addr = 16'h0040; p1_wdata = 16'h7777;
        @(negedge clk);
        check("rstw_ready", 32'(p1_ready), 32'd1);
        @(posedge clk); #1;
        idle_inputs();
        rst = 1;
        @(negedge clk);
        check("rstw_issue_we", 32'(mem_we), 32'd1);
        @(posedge clk); #1;
        rst = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rstw_mem_we", 32'(mem_we), 32'd0);
            check("rstw_rvalid", 32'({p1_rvalid, p0_rvalid}), 32'd0);
            check("rstw_mem_a",  32'(mem_a), 32'd0);
            check("rstw_mem_wd", 32'(mem_wd), 32'd0);
            check("rstw_rdata",  32'(rdata), 32'd0);
            check("rstw_ready",  32'({p1_ready, p0_ready}), 32'd0);
        end
        @(posedge clk); #1;

`ifdef MEM_ARB_STATS_EN
        check("stats_rst0", 32'(grant_cnt0), 32'd0);
        check("stats_rst1", 32'(grant_cnt1), 32'd0);
        for (int k = 0; k < 5; k++) do_access(1'b0, 1'b0, 16'(k));
        for (int k = 0; k < 2; k++) do_access(1'b1, 1'b0, 16'(k));
        check("stats_cnt0", 32'(grant_cnt0), 32'd5);
        check("stats_cnt1", 32'(grant_cnt1), 32'd2);
        $display("[TB] stats grant_cnt0=%0d grant_cnt1=%0d", grant_cnt0, grant_cnt1);
        do_reset();
        check("stats_clr0", 32'(grant_cnt0), 32'd0);
        check("stats_clr1", 32'(grant_cnt1), 32'd0);
`else
        do_access(1'b0, 1'b0, 16'h0003);
`endif

        // Randomized run against a transaction-level model
        do_reset();
        for (int i = 0; i < 256; i++) shadow[i] = mem[i];
        for (int p = 0; p < 2; p++) begin
            pend_v[p] = 0; pend_we[p] = 0; pend_addr[p] = '0; pend_wd[p] = '0;
        end
        skipped = 0;
        last_rdata = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            bit   busy, have_issue;
            int   g;
            logic p1_req;
            logic [1:0] exp_rv;
            rec_t iss;
            for (int p = 0; p < 2; p++) begin
                if (!pend_v[p] && $urandom_range(0, 3) != 0) begin
                    pend_v[p]         = 1;
                    pend_we[p]        = 1'($urandom_range(0, 1));
                    pend_addr[p][7:0] = 8'($urandom_range(0, 31));
                    pend_addr[p][15:8] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
                    pend_wd[p]        = 16'($urandom);
                end
            end
            p0_valid = pend_v[0]; p0_we = pend_we[0]; p0_addr = pend_addr[0]; p0_wdata = pend_wd[0];
            p1_valid = pend_v[1]; p1_we = pend_we[1]; p1_addr = pend_addr[1]; p1_wdata = pend_wd[1];

            busy = 0; have_issue = 0; exp_rv = 2'b00; iss = '{0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0};
            foreach (q[j]) begin
                if (q[j].acc == cyc - 1) begin busy = 1; have_issue = 1; iss = q[j]; end
                if (q[j].acc == cyc - 2 && !q[j].we) begin
                    exp_rv = q[j].port ? 2'b10 : 2'b01;
                    last_rdata = q[j].rd;
                end
            end
            g = -1;
            if (!busy && pend_v[1] && (skipped == LIMIT || !pend_v[0])) g = 1;
            else if (!busy && pend_v[0]) g = 0;

            @(negedge clk);
            check("rnd_ready", 32'({p1_ready, p0_ready}), (g == 1) ? 32'd2 : (g == 0) ? 32'd1 : 32'd0);
            check("rnd_rvalid", 32'({p1_rvalid, p0_rvalid}), 32'(exp_rv));
            check("rnd_rdata", 32'(rdata), 32'(last_rdata));
            check("rnd_mem_we", 32'(mem_we), 32'(have_issue && iss.we));
            if (have_issue) begin
                check("rnd_mem_a", 32'(mem_a), 32'(iss.addr));
                if (iss.we) check("rnd_mem_wd", 32'(mem_wd), 32'(iss.wd));
            end

            p1_req = pend_v[1];
            if (g >= 0) begin
                rec_t r;
                r.acc = cyc; r.port = 1'(g); r.we = pend_we[g];
                r.addr = pend_addr[g]; r.wd = pend_wd[g]; r.rd = '0;
                if (r.we) shadow[r.addr[7:0]] = r.wd;
                else      r.rd = shadow[r.addr[7:0]];
                q.push_back(r);
                pend_v[g] = 0;
                $display("[TB] rnd cyc %0d grant p%0d %s addr=%h data=%h", cyc, g,
                         r.we ? "WR" : "RD", r.addr, r.we ? r.wd : r.rd);
            end
            if (!p1_req || g == 1) skipped = 0;
            else if (g == 0) skipped++;
            while (q.size() > 0 && q[0].acc < cyc - 2) void'(q.pop_front());

            @(posedge clk); #1;
        end
        idle_inputs();
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: WIDTH, default 16, data and address width of the memory data port; STARVE_LIMIT, default 4, the number of consecutive port-0 grants allowed while port 1 waits.
REQ-002 clk  input  1  single clock; all state SHALL change on the rising edge only.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 p0_valid / p1_valid  input  1  request pending: p0 is the pipeline MEM stage, p1 is the loader/debug port.
REQ-005 p0_ready / p1_ready  output  1  request accepted this cycle.
REQ-006 p0_we / p1_we  input  1  1 = write, 0 = read.
REQ-007 p0_addr / p1_addr  input  WIDTH  word address.
REQ-008 p0_wdata / p1_wdata  input  WIDTH  write data.
REQ-009 p0_rvalid / p1_rvalid  output  1  one-cycle pulse: read data is valid.
REQ-010 rdata  output  WIDTH  read data, shared by both ports and qualified by the rvalid strobes.
REQ-011 mem_we  output  1  drives the write enable of the memory data port.
REQ-012 mem_a  output  WIDTH  drives the data-port address.
REQ-013 mem_wd  output  WIDTH  drives the data-port write data.
REQ-014 mem_rd  input  WIDTH  memory data-port read data; combinational from mem_a within the same cycle.

Function
REQ-015 The FSM SHALL have two states: IDLE and ISSUE.
REQ-016 In IDLE with any valid asserted, the block SHALL assert exactly one ready, combinationally, latch that port's we, addr, wdata and id, and move to ISSUE.
REQ-017 In ISSUE, mem_a, mem_wd and mem_we SHALL be driven from the latched fields, ready SHALL be 0 on both ports, and the next state SHALL be IDLE.
REQ-018 mem_we SHALL be 0 in every cycle except an ISSUE cycle for a write.
REQ-019 On a read, rdata SHALL capture mem_rd at the edge that ends ISSUE, and the owner's rvalid SHALL pulse for exactly the following cycle.
REQ-020 Read latency SHALL be 2 cycles: accepted at T, rvalid at T+2. Maximum throughput SHALL be one access per 2 cycles.
REQ-021 Writes SHALL produce no rvalid pulse.
REQ-022 rdata SHALL hold its last value until the next read completes.
REQ-023 Arbitration SHALL use fixed priority to p0, except as stated in REQ-024.
REQ-024 Starvation counter: it SHALL increment on each p0 grant while p1_valid=1, and clear on a p1 grant or when p1_valid=0. When the counter equals STARVE_LIMIT, p1 SHALL win the next arbitration.
REQ-025 A requester SHALL hold its fields stable while valid=1 and ready=0. The arbiter SHALL NOT require valid to remain high after ready.
REQ-026 A simultaneous rvalid pulse and new acceptance in the same IDLE cycle SHALL be legal.
REQ-027 Addresses SHALL be passed unmodified, with no wrap or range checking.

Reset
REQ-028 While rst=1, at the next edge the block SHALL set: state IDLE, both ready 0, both rvalid 0, rdata 0, mem_we 0, mem_a 0, mem_wd 0, latched fields 0, starvation counter 0.
REQ-029 If rst is asserted during ISSUE, the pending access SHALL be abandoned with no rvalid pulse. mem_we SHALL be 0 from the cycle after the reset edge.

Configuration
REQ-030 When MEM_ARB_STATS_EN is defined, the block SHALL add outputs grant_cnt0 and grant_cnt1, each WIDTH bits, counting accepted requests per port. The counters SHALL saturate at all-ones and clear on rst.
REQ-031 Without MEM_ARB_STATS_EN, the counter outputs and logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-032 Package mem_arb_pkg SHALL hold the state enum (IDLE, ISSUE), the port-id typedef (1 bit: P0=0, P1=1) and the STARVE_LIMIT default constant.
REQ-033 One sub-module, mem_arb_pick, SHALL contain the combinational priority and starvation-override selection. Its inputs SHALL be the two valids and the counter-at-limit flag; its output SHALL be the one-hot grant.

Verification
REQ-034 Read through p0: p0 read addr 0x0005 with mem_rd=0xBEEF while mem_a=5 -> p0_ready at T, mem_a=0x0005 at T+1, p0_rvalid=1 and rdata=0xBEEF at T+2.
REQ-035 Write through p1: p1 write addr 0x0010, data 0x1234 -> mem_we=1, mem_a=0x0010, mem_wd=0x1234 for exactly one cycle, and no p1_rvalid pulse.
REQ-036 Contention: both valid continuously, STARVE_LIMIT=4 -> grant order p0, p0, p0, p0, p1, p0, and so on.
REQ-037 Back-to-back: p0 issues 3 reads continuously -> ready pulses every 2 cycles, and each rvalid follows its own acceptance by 2 cycles.
REQ-038 Reset: rst asserted in the ISSUE cycle of a write -> mem_we=0 from the next cycle, no rvalid, and all outputs at their reset values.
REQ-039 With MEM_ARB_STATS_EN: 5 p0 grants and 2 p1 grants -> grant_cnt0=5 and grant_cnt1=2; both return to 0 after rst.
